// File: rtl/cas_fsk_player_if.sv
// -----------------------------------------------------------------------------
// cas_fsk_player_if
// Tape-image download bus feeding the cassette playback engine.
//   dl_active : tape download in progress
//   dl_wr     : write strobe for one download byte
//   dl_addr   : download byte address (ADDR_W bits)
//   dl_data   : download byte
// Modports: master drives the bus (loader side), slave receives it (player).
// -----------------------------------------------------------------------------
interface cas_fsk_player_if #(
    parameter int ADDR_W = 16
) ();
    logic              dl_active;
    logic              dl_wr;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;

    modport master (output dl_active, dl_wr, dl_addr, dl_data);
    modport slave  (input  dl_active, dl_wr, dl_addr, dl_data);
endinterface

// File: rtl/cas_fsk_player.sv
// -----------------------------------------------------------------------------
// cas_fsk_player
// Cassette playback engine: stores a tape image in an internal byte buffer
// (filled over the download bus) and replays it as a CoCo FSK square wave,
// LSB first, one F1_HZ cycle per 1 bit and one F0_HZ cycle per 0 bit, while
// the motor relay is closed. Supports bit-granular pause, end-of-tape flag
// and gap-free byte-to-byte prefetch.
// Ports:
//   clk_sys   : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   dl        : download bus (cas_fsk_player_if.slave)
//   motor     : cassette relay, 1 = play
//   rewind    : 1 = return to position 0
//   cas_bit   : FSK square wave output
//   cas_audio : monitor audio
//   playing   : 1 while emitting bit cells
//   eot       : end of tape reached
//   tape_pos  : index of byte being played
//   tape_len  : bytes loaded (highest written address + 1)
// Optional feature macro: CAS_AUDIO_EN (registered monitor audio); when
// undefined cas_audio is tied to 0.
// -----------------------------------------------------------------------------
module cas_fsk_player #(
    parameter int ADDR_W = 16,
    parameter int CLK_HZ = 57272727,
    parameter int F0_HZ  = 1200,
    parameter int F1_HZ  = 2400,
    parameter int AUD_W  = 6
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    cas_fsk_player_if.slave   dl,
    input  logic              motor,
    input  logic              rewind,
    output logic              cas_bit,
    output logic [AUD_W-1:0]  cas_audio,
    output logic              playing,
    output logic              eot,
    output logic [ADDR_W-1:0] tape_pos,
    output logic [ADDR_W:0]   tape_len
);
    localparam int H0    = CLK_HZ / (2 * F0_HZ);
    localparam int H1    = CLK_HZ / (2 * F1_HZ);
    localparam int CNT_W = $clog2(H0 + 1);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] H0_LAST = CNT_W'(H0 - 1);
    localparam logic [CNT_W-1:0] H1_LAST = CNT_W'(H1 - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HI    = 3'd3,
        ST_LO    = 3'd4,
        ST_PAUSE = 3'd5,
        ST_EOT   = 3'd6
    } state_t;

    state_t            state_r, state_nx_s;
    logic [ADDR_W-1:0] pos_r, pos_nx_s;
    logic [7:0]        shreg_r, shreg_nx_s;
    logic [2:0]        bitcnt_r, bitcnt_nx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    logic [ADDR_W:0]   tape_len_r, tape_len_nx_s, len_base_s, wr_len_s;
    logic [ADDR_W:0]   pos_ext_s, pos_inc_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [7:0]        rd_data_r;
    logic [7:0]        mem_r [0:DEPTH-1];
    logic              cas_bit_r, playing_r, eot_r, dl_act_d_r;
    logic              dl_rise_s, half_last_s, in_tape_s, last_byte_s;

    // Position compares are done one bit wider so a full buffer never wraps.
    assign pos_ext_s   = {1'b0, pos_r};
    assign pos_inc_s   = pos_ext_s + (ADDR_W+1)'(1'b1);
    assign wr_len_s    = {1'b0, dl.dl_addr} + (ADDR_W+1)'(1'b1);
    assign in_tape_s   = (pos_ext_s < tape_len_r);
    assign last_byte_s = (pos_inc_s == tape_len_r);
    assign dl_rise_s   = dl.dl_active & ~dl_act_d_r;
    // Half-cell length follows the bit currently at the bottom of the shifter.
    assign half_last_s = (cnt_r == (shreg_r[0] ? H1_LAST : H0_LAST));

    // Tape buffer: download write port, synchronous 1-cycle read port.
    always_ff @(posedge clk_sys) begin
        if (dl.dl_wr) begin
            mem_r[dl.dl_addr] <= dl.dl_data;
        end
        rd_data_r <= mem_r[rd_addr_s];
    end

    // Tape length: cleared by a new download, grows to cover the highest byte written.
    always_comb begin
        len_base_s = dl_rise_s ? {(ADDR_W+1){1'b0}} : tape_len_r;
        if (dl.dl_wr && (wr_len_s > len_base_s)) begin
            tape_len_nx_s = wr_len_s;
        end else begin
            tape_len_nx_s = len_base_s;
        end
    end

    // Playback FSM next-state: download beats rewind, rewind beats every transition.
    always_comb begin
        state_nx_s  = state_r;
        pos_nx_s    = pos_r;
        shreg_nx_s  = shreg_r;
        bitcnt_nx_s = bitcnt_r;
        cnt_nx_s    = cnt_r;
        // Outside FETCH the read port prefetches the next byte, so its data is
        // ready at the end-of-byte boundary with no gap cycles.
        rd_addr_s   = pos_inc_s[ADDR_W-1:0];
        if (dl.dl_active) begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = {CNT_W{1'b0}};
            if (dl_rise_s) begin
                pos_nx_s = {ADDR_W{1'b0}};
            end else begin
                pos_nx_s = pos_r;
            end
        end else if (rewind) begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = {CNT_W{1'b0}};
            pos_nx_s   = {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (motor && in_tape_s) begin
                        state_nx_s = ST_FETCH;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    rd_addr_s  = pos_r;
                    state_nx_s = ST_LOAD;
                end
                ST_LOAD: begin
                    shreg_nx_s  = rd_data_r;
                    bitcnt_nx_s = 3'd0;
                    cnt_nx_s    = {CNT_W{1'b0}};
                    state_nx_s  = ST_HI;
                end
                ST_HI: begin
                    if (half_last_s) begin
                        cnt_nx_s   = {CNT_W{1'b0}};
                        state_nx_s = ST_LO;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_W'(1'b1);
                    end
                end
                ST_LO: begin
                    if (!half_last_s) begin
                        cnt_nx_s = cnt_r + CNT_W'(1'b1);
                    end else begin
                        // Bit boundary: the only place motor is looked at.
                        cnt_nx_s = {CNT_W{1'b0}};
                        if (bitcnt_r == 3'd7) begin
                            if (last_byte_s) begin
                                state_nx_s = ST_EOT;
                            end else begin
                                shreg_nx_s  = rd_data_r;
                                bitcnt_nx_s = 3'd0;
                                pos_nx_s    = pos_r + ADDR_W'(1'b1);
                                state_nx_s  = motor ? ST_HI : ST_PAUSE;
                            end
                        end else begin
                            shreg_nx_s  = {1'b0, shreg_r[7:1]};
                            bitcnt_nx_s = bitcnt_r + 3'd1;
                            state_nx_s  = motor ? ST_HI : ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (motor) begin
                        state_nx_s = ST_HI;
                    end else begin
                        state_nx_s = ST_PAUSE;
                    end
                end
                ST_EOT: begin
                    state_nx_s = ST_EOT;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs (outputs decoded from next state).
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            pos_r      <= {ADDR_W{1'b0}};
            shreg_r    <= 8'h00;
            bitcnt_r   <= 3'd0;
            cnt_r      <= {CNT_W{1'b0}};
            tape_len_r <= {(ADDR_W+1){1'b0}};
            dl_act_d_r <= 1'b0;
            cas_bit_r  <= 1'b0;
            playing_r  <= 1'b0;
            eot_r      <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            pos_r      <= pos_nx_s;
            shreg_r    <= shreg_nx_s;
            bitcnt_r   <= bitcnt_nx_s;
            cnt_r      <= cnt_nx_s;
            tape_len_r <= tape_len_nx_s;
            dl_act_d_r <= dl.dl_active;
            cas_bit_r  <= (state_nx_s == ST_HI);
            playing_r  <= (state_nx_s == ST_HI) || (state_nx_s == ST_LO);
            eot_r      <= (state_nx_s == ST_EOT);
        end
    end

    assign cas_bit  = cas_bit_r;
    assign playing  = playing_r;
    assign eot      = eot_r;
    assign tape_pos = pos_r;
    assign tape_len = tape_len_r;

`ifdef CAS_AUDIO_EN
    localparam logic [AUD_W-1:0] AUD_HI = {1'b0, {(AUD_W-1){1'b1}}};
    logic [AUD_W-1:0] audio_r;

    // Monitor audio follows the played square wave one cycle later.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            audio_r <= {AUD_W{1'b0}};
        end else begin
            audio_r <= (playing_r & cas_bit_r) ? AUD_HI : {AUD_W{1'b0}};
        end
    end

    assign cas_audio = audio_r;
`else
    assign cas_audio = {AUD_W{1'b0}};
`endif
endmodule
